uart_ctrl: RTL and testbench
============================

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h4000_0000, meaning the peripheral page base; only addr[31:8] is compared.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port addr, input, 32 bits: CPU data-bus byte address, word aligned.
REQ-005 SHALL have port wdata, input, 32 bits: CPU store data.
REQ-006 SHALL have ports rd and wr, input, 1 bit each: CPU MemRead and MemWrite strobes, one cycle per access.
REQ-007 SHALL have port rdata, output, 32 bits: combinational read data.
REQ-008 SHALL have ports rx_data, input, 8 bits, and rx_valid, input, 1 bit: received byte and its one-cycle strobe from the receiver.
REQ-009 SHALL have ports tx_data, output, 8 bits, and tx_start, output, 1 bit: byte and one-cycle launch pulse to the transmitter.
REQ-010 SHALL have port tx_busy, input, 1 bit: transmitter shifting.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-012 SHALL decode TXD at offset 0x18, RXD at 0x1C and CON at 0x20; any other offset reads 0 and ignores writes.
REQ-013 SHALL return the following on rdata in the same cycle as the access: TXD {24'b0, last written byte}; RXD {24'b0, rx buffer}; CON {26'b0, OVR[5], TX_BUSY[4], RX_VALID[3], TX_DONE[2], IE_RX[1], IE_TX[0]}.
REQ-014 SHALL let a CON write update only IE_RX and IE_TX; wdata bits [31:2] are ignored. A write of 0x14 therefore clears both enables.
REQ-015 SHALL, on rx_valid, latch rx_data into the rx buffer and set RX_VALID; if RX_VALID was already 1, it SHALL also set OVR and overwrite the buffer.
REQ-016 SHALL clear RX_VALID on the edge ending an RXD read; if rx_valid arrives in the same cycle, the new byte is latched and RX_VALID stays 1.
REQ-017 SHALL clear TX_DONE and OVR on the edge ending a CON read; a same-cycle set event wins.
REQ-018 SHALL run the TX FSM with states IDLE, LAUNCH, WAIT, ACTIVE:
- IDLE to LAUNCH on a TXD write, latching wdata[7:0] into tx_data.
- LAUNCH drives tx_start=1 for exactly one cycle, then goes to WAIT.
- WAIT goes to ACTIVE when tx_busy=1.
- ACTIVE goes to IDLE when tx_busy=0, setting TX_DONE.
REQ-019 SHALL ignore TXD writes when the FSM is not in IDLE; tx_data is left unchanged and no pulse is issued.
REQ-020 SHALL drive TX_BUSY = (FSM != IDLE), so TX_BUSY reads 1 starting the cycle after the TXD write.
REQ-021 SHALL drive irq = (IE_RX & RX_VALID) | (IE_TX & TX_DONE), registered-state based with no combinational path from the bus.
REQ-022 SHALL ignore rd/wr strobes when addr does not match BASE_ADDR page.

Reset
REQ-023 SHALL, on reset, clear all of the following: FSM to IDLE, tx_start=0, tx_data=0, rx buffer=0, RX_VALID, TX_DONE, OVR, IE_RX, IE_TX, irq=0.
REQ-024 SHALL, when reset is asserted mid-transfer, abandon the transfer without issuing a tx_start and without setting TX_DONE.

Structure
REQ-025 SHALL place register offsets, CON bit positions and the TX FSM state encoding in a shared package used by the CPU peripheral decoder and the testbench.
REQ-026 SHALL implement the TX FSM as one sub-module, uart_tx_seq, exporting tx_start, busy and a done pulse.

Verification
REQ-027 SHALL cover reset: assert reset mid-WAIT -> all outputs 0, CON reads 0x00 the next cycle.
REQ-028 SHALL cover receive: rx_valid with 0x24 -> CON reads 0x08; RXD read returns 0x24; CON then reads 0x00.
REQ-029 SHALL cover overrun: two rx_valid (0x11, 0x22) with no read -> RXD=0x22, CON=0x28; the CON read clears OVR, then CON=0x08.
REQ-030 SHALL cover transmit: TXD write 0x06 -> tx_start high exactly one cycle with tx_data=0x06, and CON bit4=1. With tx_busy high for 10 cycles then low -> CON=0x04, and the next CON read returns 0x00.
REQ-031 SHALL cover busy drop: a TXD write 0x07 while ACTIVE -> no tx_start and tx_data stays 0x06.
REQ-032 SHALL cover interrupts: CON write 0x03, then rx_valid -> irq=1; RXD read -> irq=0; after a TX completes -> irq=1 until CON is read.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared definitions for the UART CPU peripheral.
//   - register offsets within the peripheral page (addr[7:0])
//   - bit positions inside the CON status/control register
//   - TX launch sequencer state encoding
package uart_ctrl_pkg;

    localparam logic [7:0] OFF_TXD = 8'h18;
    localparam logic [7:0] OFF_RXD = 8'h1C;
    localparam logic [7:0] OFF_CON = 8'h20;

    localparam int CON_IE_TX    = 0;
    localparam int CON_IE_RX    = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_VALID = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_OVR      = 5;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LAUNCH = 2'd1,
        TX_WAIT   = 2'd2,
        TX_ACTIVE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_seq.sv
// uart_tx_seq: launches one byte into the external transmitter and tracks it
// until the transmitter reports idle again.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   load_i       : TXD write strobe (ignored unless idle)
//   data_i       : byte to send, captured on an accepted load
//   tx_busy_i    : transmitter is shifting
//   tx_start_o   : one-cycle launch pulse
//   tx_data_o    : byte presented to the transmitter
//   busy_o       : sequencer not idle
//   done_o       : one-cycle pulse when the transmitter finishes
module uart_tx_seq
    import uart_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       tx_busy_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic       busy_o,
    output logic       done_o
);

    tx_state_e  state_q, state_d;
    logic [7:0] data_q,  data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_o  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (load_i) begin
                    state_d = TX_LAUNCH;
                    data_d  = data_i;
                end
            end
            TX_LAUNCH: state_d = TX_WAIT;
            TX_WAIT: begin
                if (tx_busy_i) state_d = TX_ACTIVE;
            end
            TX_ACTIVE: begin
                if (!tx_busy_i) begin
                    state_d = TX_IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Gated by reset so a transfer caught in LAUNCH is abandoned silently.
    assign tx_start_o = (state_q == TX_LAUNCH) && !reset;
    assign tx_data_o  = data_q;
    assign busy_o     = (state_q != TX_IDLE);

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped UART control block on the CPU data bus.
// Registers (page selected by addr[31:8] == BASE_ADDR[31:8]):
//   TXD 0x18 : write launches a byte; read returns last accepted byte
//   RXD 0x1C : read returns the rx buffer and clears RX_VALID
//   CON 0x20 : status/enables; read clears TX_DONE and OVR,
//              write updates IE_RX/IE_TX only
// Ports: clk, reset (sync, active high), addr/wdata/rd/wr CPU bus,
//   rdata (combinational), rx_data/rx_valid from receiver,
//   tx_data/tx_start/tx_busy to/from transmitter, irq level interrupt.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        irq
);

    logic page_hit, sel_txd, sel_rxd, sel_con;
    logic wr_txd, rd_rxd, rd_con, wr_con;
    logic seq_busy, seq_done;

    logic [7:0] rx_buf_q,   rx_buf_d;
    logic       rx_valid_q, rx_valid_d;
    logic       ovr_q,      ovr_d;
    logic       tx_done_q,  tx_done_d;
    logic       ie_rx_q,    ie_rx_d;
    logic       ie_tx_q,    ie_tx_d;
    logic [5:0] con;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    assign page_hit = (addr[31:8] == BASE_ADDR[31:8]);
    assign sel_txd  = page_hit && (addr[7:0] == OFF_TXD);
    assign sel_rxd  = page_hit && (addr[7:0] == OFF_RXD);
    assign sel_con  = page_hit && (addr[7:0] == OFF_CON);
    assign wr_txd   = wr && sel_txd;
    assign rd_rxd   = rd && sel_rxd;
    assign rd_con   = rd && sel_con;
    assign wr_con   = wr && sel_con;

    uart_tx_seq u_tx_seq (
        .clk        (clk),
        .reset      (reset),
        .load_i     (wr_txd),
        .data_i     (wdata[7:0]),
        .tx_busy_i  (tx_busy),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .busy_o     (seq_busy),
        .done_o     (seq_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_buf_q   <= 8'h00;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            tx_done_q  <= 1'b0;
            ie_rx_q    <= 1'b0;
            ie_tx_q    <= 1'b0;
        end else begin
            rx_buf_q   <= rx_buf_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            tx_done_q  <= tx_done_d;
            ie_rx_q    <= ie_rx_d;
            ie_tx_q    <= ie_tx_d;
        end
    end

    // Set events are checked first so they win over a same-cycle read-clear.
    always_comb begin
        rx_buf_d   = rx_buf_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        tx_done_d  = tx_done_q;
        ie_rx_d    = ie_rx_q;
        ie_tx_d    = ie_tx_q;

        if (rx_valid) begin
            rx_buf_d   = rx_data;
            rx_valid_d = 1'b1;
        end else if (rd_rxd) begin
            rx_valid_d = 1'b0;
        end

        if (rx_valid && rx_valid_q) ovr_d = 1'b1;
        else if (rd_con)            ovr_d = 1'b0;

        if (seq_done)    tx_done_d = 1'b1;
        else if (rd_con) tx_done_d = 1'b0;

        if (wr_con) begin
            ie_rx_d = wdata[CON_IE_RX];
            ie_tx_d = wdata[CON_IE_TX];
        end
    end

    always_comb begin
        con               = '0;
        con[CON_IE_TX]    = ie_tx_q;
        con[CON_IE_RX]    = ie_rx_q;
        con[CON_TX_DONE]  = tx_done_q;
        con[CON_RX_VALID] = rx_valid_q;
        con[CON_TX_BUSY]  = seq_busy;
        con[CON_OVR]      = ovr_q;
    end

    always_comb begin
        rdata = 32'h0;
        if (sel_txd)      rdata = {24'h0, tx_data};
        else if (sel_rxd) rdata = {24'h0, rx_buf_q};
        else if (sel_con) rdata = {26'h0, con};
    end

    // Built only from flops, so no bus input reaches irq combinationally.
    assign irq = (ie_rx_q & rx_valid_q) | (ie_tx_q & tx_done_q);

endmodule

// File: tb/tb_uart_ctrl.sv
module tb_uart_ctrl;
    import uart_ctrl_pkg::*;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam logic [31:0] A_TXD = BASE + {24'h0, OFF_TXD};
    localparam logic [31:0] A_RXD = BASE + {24'h0, OFF_RXD};
    localparam logic [31:0] A_CON = BASE + {24'h0, OFF_CON};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        rd = 1'b0, wr = 1'b0;
    logic [7:0]  rx_data = '0, tx_data;
    logic        rx_valid = 1'b0, tx_start, tx_busy = 1'b0, irq;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    logic [31:0] exp_q[$];

    uart_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
        .rdata(rdata), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (tx_start) start_cnt <= start_cnt + 1;

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); addr = a; rd = 1'b1;
        #1 d = rdata;
        @(posedge clk); #1 rd = 1'b0; addr = '0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk); addr = a; wdata = w; wr = 1'b1;
        @(posedge clk); #1 wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk); rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d, e;
        // power-on state
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, irq} !== e) begin n_err++; $display("FAIL por_irq: got %h want %h", irq, e); end
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, tx_start} !== e) begin n_err++; $display("FAIL por_tx_start: got %h want %h", tx_start, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL por_con: got %h want %h", d, e); end
        do_read(A_TXD, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL por_txd: got %h want %h", d, e); end
        do_read(A_RXD, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL por_rxd: got %h want %h", d, e); end

        // build up state, park the sequencer in WAIT, then reset
        do_write(A_CON, 32'h3);
        rx_byte(8'h99);
        do_write(A_TXD, 32'h55);
        @(posedge clk); #1;
        exp_q.push_back(32'h1); // irq before reset
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, irq} !== e) begin n_err++; $display("FAIL pre_rst_irq: got %h want %h", irq, e); end
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, tx_start} !== e) begin n_err++; $display("FAIL rst_tx_start: got %h want %h", tx_start, e); end
        n_cmp++; e = exp_q.pop_front(); if ({24'h0, tx_data} !== e) begin n_err++; $display("FAIL rst_tx_data: got %h want %h", tx_data, e); end
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, irq} !== e) begin n_err++; $display("FAIL rst_irq: got %h want %h", irq, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL rst_con: got %h want %h", d, e); end
        do_read(A_RXD, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL rst_rxd: got %h want %h", d, e); end
        // tx_busy activity after reset must not produce a TX_DONE
        @(negedge clk); tx_busy = 1'b1;
        repeat (3) @(negedge clk); tx_busy = 1'b0;
        exp_q.push_back(32'h0);
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL rst_no_done: got %h want %h", d, e); end
    endtask

    task automatic test_receive;
        logic [31:0] d, e;
        rx_byte(8'h24);
        exp_q.push_back(32'h08); exp_q.push_back(32'h24); exp_q.push_back(32'h00);
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL rx_con: got %h want %h", d, e); end
        do_read(A_RXD, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL rx_rxd: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL rx_con_after: got %h want %h", d, e); end
    endtask

    task automatic test_overrun;
        logic [31:0] d, e;
        rx_byte(8'h11);
        rx_byte(8'h22);
        exp_q.push_back(32'h28); exp_q.push_back(32'h08);
        exp_q.push_back(32'h22); exp_q.push_back(32'h00);
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL ovr_con: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL ovr_con_clr: got %h want %h", d, e); end
        do_read(A_RXD, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL ovr_rxd: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL ovr_con_end: got %h want %h", d, e); end
    endtask

    task automatic test_transmit;
        logic [31:0] d, e;
        int s0;
        s0 = start_cnt;
        exp_q.push_back(32'h1); exp_q.push_back(32'h06); exp_q.push_back(32'h0);
        exp_q.push_back(32'h10); exp_q.push_back(32'h04); exp_q.push_back(32'h00);
        exp_q.push_back(32'h1);
        do_write(A_TXD, 32'h06);
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, tx_start} !== e) begin n_err++; $display("FAIL tx_start_hi: got %h want %h", tx_start, e); end
        n_cmp++; e = exp_q.pop_front(); if ({24'h0, tx_data} !== e) begin n_err++; $display("FAIL tx_data: got %h want %h", tx_data, e); end
        @(posedge clk); #1;
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, tx_start} !== e) begin n_err++; $display("FAIL tx_start_lo: got %h want %h", tx_start, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL tx_con_busy: got %h want %h", d, e); end
        @(negedge clk); tx_busy = 1'b1;
        repeat (10) @(negedge clk);
        tx_busy = 1'b0;
        @(posedge clk); #1;
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL tx_con_done: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL tx_con_clr: got %h want %h", d, e); end
        n_cmp++; e = exp_q.pop_front(); if (start_cnt - s0 !== int'(e)) begin n_err++; $display("FAIL tx_pulses: got %0d want %0d", start_cnt - s0, e); end
    endtask

    task automatic test_busy_drop;
        logic [31:0] d, e;
        int s0;
        s0 = start_cnt;
        exp_q.push_back(32'h06); exp_q.push_back(32'h06); exp_q.push_back(32'h10);
        exp_q.push_back(32'h04); exp_q.push_back(32'h1);
        do_write(A_TXD, 32'h06);
        @(negedge clk); tx_busy = 1'b1;
        repeat (2) @(posedge clk);
        do_write(A_TXD, 32'h07);
        @(posedge clk); #1;
        n_cmp++; e = exp_q.pop_front(); if ({24'h0, tx_data} !== e) begin n_err++; $display("FAIL drop_tx_data: got %h want %h", tx_data, e); end
        do_read(A_TXD, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL drop_txd: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL drop_con: got %h want %h", d, e); end
        @(negedge clk); tx_busy = 1'b0;
        @(posedge clk); #1;
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL drop_con_done: got %h want %h", d, e); end
        n_cmp++; e = exp_q.pop_front(); if (start_cnt - s0 !== int'(e)) begin n_err++; $display("FAIL drop_pulses: got %0d want %0d", start_cnt - s0, e); end
    endtask

    task automatic test_interrupts;
        logic [31:0] d, e;
        exp_q.push_back(32'h03); exp_q.push_back(32'h1); exp_q.push_back(32'h5A);
        exp_q.push_back(32'h0);  exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        exp_q.push_back(32'h07); exp_q.push_back(32'h0); exp_q.push_back(32'h00);
        do_write(A_CON, 32'h3);
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL irq_con_ie: got %h want %h", d, e); end
        rx_byte(8'h5A);
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, irq} !== e) begin n_err++; $display("FAIL irq_rx_hi: got %h want %h", irq, e); end
        do_read(A_RXD, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL irq_rxd: got %h want %h", d, e); end
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, irq} !== e) begin n_err++; $display("FAIL irq_rx_lo: got %h want %h", irq, e); end
        do_write(A_TXD, 32'h41);
        @(negedge clk); tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        @(posedge clk); #1;
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, irq} !== e) begin n_err++; $display("FAIL irq_tx_hi: got %h want %h", irq, e); end
        repeat (2) @(posedge clk); #1;
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, irq} !== e) begin n_err++; $display("FAIL irq_tx_hold: got %h want %h", irq, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL irq_con: got %h want %h", d, e); end
        n_cmp++; e = exp_q.pop_front(); if ({31'h0, irq} !== e) begin n_err++; $display("FAIL irq_tx_lo: got %h want %h", irq, e); end
        do_write(A_CON, 32'h14);
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL irq_ie_clr: got %h want %h", d, e); end
    endtask

    task automatic test_decode;
        logic [31:0] d, e;
        int s0;
        s0 = start_cnt;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h41);
        exp_q.push_back(32'h0); exp_q.push_back(32'h08); exp_q.push_back(32'h33);
        exp_q.push_back(32'h00);
        do_read(BASE + 32'h24, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL dec_unmapped: got %h want %h", d, e); end
        do_write(32'h5000_0018, 32'hAA);
        do_write(32'h5000_0020, 32'h3);
        repeat (2) @(posedge clk); #1;
        n_cmp++; e = exp_q.pop_front(); if (start_cnt - s0 !== int'(e)) begin n_err++; $display("FAIL dec_no_start: got %0d want %0d", start_cnt - s0, e); end
        n_cmp++; e = exp_q.pop_front(); if ({24'h0, tx_data} !== e) begin n_err++; $display("FAIL dec_tx_data: got %h want %h", tx_data, e); end
        rx_byte(8'h33);
        do_read(32'h5000_001C, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL dec_other_page: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL dec_con: got %h want %h", d, e); end
        do_read(A_RXD, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL dec_rxd: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL dec_con_end: got %h want %h", d, e); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d, e;
        exp_q.push_back(32'h01); exp_q.push_back(32'h28); exp_q.push_back(32'h08);
        exp_q.push_back(32'h02); exp_q.push_back(32'h00);
        rx_byte(8'h01);
        // RXD read and a new byte in the same cycle
        @(negedge clk); addr = A_RXD; rd = 1'b1; rx_data = 8'h02; rx_valid = 1'b1;
        #1 d = rdata;
        @(posedge clk); #1 rd = 1'b0; rx_valid = 1'b0; addr = '0;
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL b2b_rxd_old: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL b2b_con: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL b2b_con_clr: got %h want %h", d, e); end
        do_read(A_RXD, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL b2b_rxd_new: got %h want %h", d, e); end
        do_read(A_CON, d);
        n_cmp++; e = exp_q.pop_front(); if (d !== e) begin n_err++; $display("FAIL b2b_con_end: got %h want %h", d, e); end
    endtask

    initial begin
        test_reset();
        test_receive();
        test_overrun();
        test_transmit();
        test_busy_drop();
        test_interrupts();
        test_decode();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
